// File: rtl/bp_me_pkg.sv
// bp_me_pkg: shared types for the cache-DMA to CCE memory adapter.
package bp_me_pkg;
  localparam int paddr_width_p = 40;
  localparam int cce_block_width_p = 512;
  localparam int dword_width_p = 64;
  localparam int mem_payload_width_p = 16;
  localparam int block_size_in_words_lp = cce_block_width_p / dword_width_p;
  localparam int counter_width_lp = (block_size_in_words_lp > 1) ? $clog2(block_size_in_words_lp) : 1;
  localparam int block_offset_lp = $clog2(cce_block_width_p / 8);
  typedef enum logic [2:0] {
    e_idle, e_rd_cmd, e_rd_resp, e_rd_fill, e_wr_collect, e_wr_cmd, e_wr_ack
  } bp_me_dma_state_e;
  typedef enum logic [3:0] {
    e_cce_mem_rd = 4'h0, e_cce_mem_wr = 4'h1, e_cce_mem_uc_rd = 4'h2, e_cce_mem_uc_wr = 4'h3
  } bp_cce_mem_cmd_type_e;
  typedef enum logic [2:0] {
    e_mem_msg_size_1, e_mem_msg_size_2, e_mem_msg_size_4, e_mem_msg_size_8,
    e_mem_msg_size_16, e_mem_msg_size_32, e_mem_msg_size_64
  } bp_mem_msg_size_e;
  typedef struct packed {
    logic write_not_read;
    logic [paddr_width_p-1:0] addr;
  } bsg_cache_dma_pkt_s;
  typedef struct packed {
    logic [cce_block_width_p-1:0] data;
    logic [mem_payload_width_p-1:0] payload;
    bp_mem_msg_size_e size;
    logic [paddr_width_p-1:0] addr;
    bp_cce_mem_cmd_type_e msg_type;
  } bp_cce_mem_msg_s;
  localparam int dma_pkt_width_lp = $bits(bsg_cache_dma_pkt_s);
  localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);
  function automatic bp_mem_msg_size_e mem_size_enc(input int block_width);
    return block_width >= 512 ? e_mem_msg_size_64
         : block_width >= 256 ? e_mem_msg_size_32
         : block_width >= 128 ? e_mem_msg_size_16 : e_mem_msg_size_8;
  endfunction
endpackage

// File: rtl/bp_me_dword_block_buffer.sv
// bp_me_dword_block_buffer: N x dword register file with per-dword and full-block write.
module bp_me_dword_block_buffer #(
  parameter int els_p = 8,
  parameter int width_p = 64,
  localparam int idx_w_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     w_v_i,
  input  logic [idx_w_lp-1:0]      w_idx_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic                     blk_w_v_i,
  input  logic [els_p*width_p-1:0] blk_data_i,
  output logic [els_p*width_p-1:0] blk_data_o
);
  logic [els_p-1:0][width_p-1:0] mem_q, mem_d;
  always_comb begin
    mem_d = mem_q;
    if (blk_w_v_i) mem_d = blk_data_i;
    else if (w_v_i) mem_d[w_idx_i] = w_data_i;
  end
  always_ff @(posedge clk_i) mem_q <= mem_d;
  assign blk_data_o = mem_q;
endmodule

// File: rtl/bp_me_cache_dma_to_cce.sv
// bp_me_cache_dma_to_cce: bsg_cache DMA fills/evictions to CCE memory commands, one block in flight.
// BP_ME_CACHE_DMA_TO_CCE_STATS_EN adds saturating read/write response counters.
module bp_me_cache_dma_to_cce
  import bp_me_pkg::*;
(
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [dma_pkt_width_lp-1:0]     dma_pkt_i,
  input  logic                            dma_pkt_v_i,
  output logic                            dma_pkt_yumi_o,
  output logic [dword_width_p-1:0]        dma_data_o,
  output logic                            dma_data_v_o,
  input  logic                            dma_data_ready_i,
  input  logic [dword_width_p-1:0]        dma_data_i,
  input  logic                            dma_data_v_i,
  output logic                            dma_data_yumi_o,
  output logic [cce_mem_msg_width_lp-1:0] mem_cmd_o,
  output logic                            mem_cmd_v_o,
  input  logic                            mem_cmd_ready_i,
  input  logic [cce_mem_msg_width_lp-1:0] mem_resp_i,
  input  logic                            mem_resp_v_i,
  output logic                            mem_resp_yumi_o
`ifdef BP_ME_CACHE_DMA_TO_CCE_STATS_EN
  ,
  output logic [31:0]                     rd_count_o,
  output logic [31:0]                     wr_count_o
`endif
);
  localparam logic [counter_width_lp-1:0] last_lp = counter_width_lp'(block_size_in_words_lp - 1);
  bp_me_dma_state_e state_q, state_d;
  logic [counter_width_lp-1:0] cnt_q, cnt_d;
  logic [paddr_width_p-1:0] addr_q, addr_d;
  bsg_cache_dma_pkt_s pkt;
  bp_cce_mem_msg_s cmd, resp;
  logic word_w_v, blk_w_v, unused;
  logic [block_size_in_words_lp-1:0][dword_width_p-1:0] blk;
  assign pkt = dma_pkt_i;
  assign resp = mem_resp_i;
  assign unused = ^{resp.payload, resp.size, pkt.addr[block_offset_lp-1:0]};
  bp_me_dword_block_buffer #(.els_p(block_size_in_words_lp), .width_p(dword_width_p)) buffer (
    .clk_i     (clk_i),
    .w_v_i     (word_w_v),
    .w_idx_i   (cnt_q),
    .w_data_i  (dma_data_i),
    .blk_w_v_i (blk_w_v),
    .blk_data_i(resp.data),
    .blk_data_o(blk)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    dma_pkt_yumi_o = 1'b0;
    dma_data_v_o = 1'b0;
    dma_data_yumi_o = 1'b0;
    mem_cmd_v_o = 1'b0;
    mem_resp_yumi_o = 1'b0;
    word_w_v = 1'b0;
    blk_w_v = 1'b0;
    case (state_q)
      e_idle: begin
        dma_pkt_yumi_o = dma_pkt_v_i & ~reset_i;
        if (dma_pkt_yumi_o) begin
          addr_d = {pkt.addr[paddr_width_p-1:block_offset_lp], block_offset_lp'(0)};
          state_d = pkt.write_not_read ? e_wr_collect : e_rd_cmd;
        end
      end
      e_rd_cmd: begin
        mem_cmd_v_o = 1'b1;
        state_d = mem_cmd_ready_i ? e_rd_resp : e_rd_cmd;
      end
      e_rd_resp: begin
        mem_resp_yumi_o = mem_resp_v_i;
        blk_w_v = mem_resp_v_i;
        state_d = mem_resp_v_i ? e_rd_fill : e_rd_resp;
      end
      e_rd_fill: begin
        dma_data_v_o = 1'b1;
        if (dma_data_ready_i) begin
          cnt_d = (cnt_q == last_lp) ? '0 : cnt_q + 1'b1;
          state_d = (cnt_q == last_lp) ? e_idle : e_rd_fill;
        end
      end
      e_wr_collect: begin
        dma_data_yumi_o = dma_data_v_i;
        word_w_v = dma_data_v_i;
        if (dma_data_v_i) begin
          cnt_d = (cnt_q == last_lp) ? '0 : cnt_q + 1'b1;
          state_d = (cnt_q == last_lp) ? e_wr_cmd : e_wr_collect;
        end
      end
      e_wr_cmd: begin
        mem_cmd_v_o = 1'b1;
        state_d = mem_cmd_ready_i ? e_wr_ack : e_wr_cmd;
      end
      e_wr_ack: begin
        mem_resp_yumi_o = mem_resp_v_i;
        state_d = mem_resp_v_i ? e_idle : e_wr_ack;
      end
      default: state_d = e_idle;
    endcase
  end
  // Header is built only from registered state, so it holds while mem_cmd_v_o waits for ready
  always_comb begin
    cmd = '0;
    cmd.msg_type = (state_q == e_wr_cmd) ? e_cce_mem_wr : e_cce_mem_rd;
    cmd.addr = addr_q;
    cmd.size = mem_size_enc(cce_block_width_p);
    cmd.data = (state_q == e_wr_cmd) ? blk : '0;
  end
  assign mem_cmd_o = cmd;
  assign dma_data_o = blk[cnt_q];
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q <= e_idle;
      cnt_q <= '0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
    end
`ifdef BP_ME_CACHE_DMA_TO_CCE_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  assign rd_cnt_d = rd_cnt_q + 32'((state_q == e_rd_resp) && mem_resp_v_i && ~&rd_cnt_q);
  assign wr_cnt_d = wr_cnt_q + 32'((state_q == e_wr_ack) && mem_resp_v_i && ~&wr_cnt_q);
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  assign rd_count_o = rd_cnt_q;
  assign wr_count_o = wr_cnt_q;
`endif
`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (reset_i)
    mem_resp_yumi_o |-> resp.msg_type == ((state_q == e_wr_ack) ? e_cce_mem_wr : e_cce_mem_rd));
  assert property (@(posedge clk_i) disable iff (reset_i) mem_resp_yumi_o |-> resp.addr == addr_q);
`endif
endmodule

// File: tb/tb_bp_me_cache_dma_to_cce.sv
// tb_bp_me_cache_dma_to_cce: randomized bench against a transaction-level memory/cache model.
module tb_bp_me_cache_dma_to_cce;
  import bp_me_pkg::*;
  localparam int N = block_size_in_words_lp;
  logic clk = 1'b0;
  logic reset_i;
  logic [dma_pkt_width_lp-1:0] dma_pkt_i;
  logic dma_pkt_v_i, dma_pkt_yumi_o;
  logic [dword_width_p-1:0] dma_data_o, dma_data_i;
  logic dma_data_v_o, dma_data_ready_i, dma_data_v_i, dma_data_yumi_o;
  logic [cce_mem_msg_width_lp-1:0] mem_cmd_o, mem_resp_i;
  logic mem_cmd_v_o, mem_cmd_ready_i, mem_resp_v_i, mem_resp_yumi_o;
  int n_chk = 0, n_fail = 0, n_rd = 0, n_wr = 0;
`ifdef BP_ME_CACHE_DMA_TO_CCE_STATS_EN
  logic [31:0] rd_count_o, wr_count_o;
`endif
  bp_me_cache_dma_to_cce dut (
    .clk_i(clk), .reset_i(reset_i),
    .dma_pkt_i(dma_pkt_i), .dma_pkt_v_i(dma_pkt_v_i), .dma_pkt_yumi_o(dma_pkt_yumi_o),
    .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o), .dma_data_ready_i(dma_data_ready_i),
    .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i), .dma_data_yumi_o(dma_data_yumi_o),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_yumi_o(mem_resp_yumi_o)
`ifdef BP_ME_CACHE_DMA_TO_CCE_STATS_EN
    , .rd_count_o(rd_count_o), .wr_count_o(wr_count_o)
`endif
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [cce_mem_msg_width_lp-1:0] got,
                       input logic [cce_mem_msg_width_lp-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic bp_cce_mem_msg_s mk_msg(input bp_cce_mem_cmd_type_e t, input logic [39:0] a,
                                             input logic [511:0] d);
    bp_cce_mem_msg_s m;
    m.msg_type = t;
    m.addr = a & ~40'h3F;
    m.size = e_mem_msg_size_64;
    m.payload = '0;
    m.data = d;
    return m;
  endfunction
  function automatic logic [511:0] rand_blk;
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction
  function automatic logic [39:0] rand_addr;
    return {8'h00, 32'($urandom)};
  endfunction
  task automatic accept_pkt(input logic wnr, input logic [39:0] a);
    int t = 0;
    dma_pkt_i = {wnr, a};
    dma_pkt_v_i = 1'b1;
    #1;
    while (!dma_pkt_yumi_o && t < 50) begin step; t++; end
    check("pkt_yumi", dma_pkt_yumi_o, 1);
    step;
    dma_pkt_v_i = 1'b0;
  endtask
  task automatic probe_idle(input string tag);
    dma_pkt_i = {1'b0, rand_addr()};
    dma_pkt_v_i = 1'b1;
    #1;
    check(tag, dma_pkt_yumi_o, 1);
    dma_pkt_v_i = 1'b0;
    #1;
  endtask
  task automatic send_cmd(input string tag, input bp_cce_mem_msg_s exp, input int hold);
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_v"}, mem_cmd_v_o, 1);
      check({tag, "_hold"}, mem_cmd_o, exp);
      check({tag, "_no_resp_yumi"}, mem_resp_yumi_o, 0);
      step;
    end
    mem_cmd_ready_i = 1'b1;
    #1;
    check({tag, "_v"}, mem_cmd_v_o, 1);
    check(tag, mem_cmd_o, exp);
    step;
    mem_cmd_ready_i = 1'b0;
  endtask
  task automatic do_read(input logic [39:0] a, input logic [511:0] d, input int hold, input int mode,
                         input int stop);
    int t = 0, k = 0;
    accept_pkt(1'b0, a);
    send_cmd("rd_cmd", mk_msg(e_cce_mem_rd, a, '0), hold);
    mem_resp_i = mk_msg(e_cce_mem_rd, a, d);
    mem_resp_v_i = 1'b1;
    #1;
    while (!mem_resp_yumi_o && t < 50) begin step; t++; end
    check("rd_resp_yumi", mem_resp_yumi_o, 1);
    step;
    n_rd++;
    mem_resp_v_i = 1'b0;
    check("rd_fill_latency", dma_data_v_o, 1);
    t = 0;
    while (k < stop && t < 200) begin
      dma_data_ready_i = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(t % 2) : 1'($urandom_range(0, 1));
      #1;
      if (dma_data_v_o && dma_data_ready_i) begin
        check("rd_fill_word", dma_data_o, d[k*64 +: 64]);
        k++;
      end
      step;
      t++;
    end
    dma_data_ready_i = 1'b0;
    check("rd_fill_count", k, stop);
    if (stop == N) begin
      check("rd_done_fill_v", dma_data_v_o, 0);
      probe_idle("rd_done_idle");
    end
  endtask
  task automatic do_write(input logic [39:0] a, input logic [511:0] d, input int hold);
    int t = 0, k = 0;
    accept_pkt(1'b1, a);
    while (k < N && t < 200) begin
      dma_data_v_i = ($urandom_range(0, 3) != 0);
      dma_data_i = d[k*64 +: 64];
      #1;
      check("wr_evict_yumi", dma_data_yumi_o, dma_data_v_i);
      if (dma_data_v_i) k++;
      step;
      t++;
    end
    dma_data_v_i = 1'b0;
    check("wr_evict_count", k, N);
    send_cmd("wr_cmd", mk_msg(e_cce_mem_wr, a, d), hold);
    dma_pkt_i = {1'b0, rand_addr()};
    dma_pkt_v_i = 1'b1;
    #1;
    for (int i = 0; i < 1 + int'($urandom_range(0, 3)); i++) begin
      check("wr_ack_not_idle", dma_pkt_yumi_o, 0);
      check("wr_ack_cmd_v", mem_cmd_v_o, 0);
      step;
    end
    dma_pkt_v_i = 1'b0;
    mem_resp_i = mk_msg(e_cce_mem_wr, a, '0);
    mem_resp_v_i = 1'b1;
    #1;
    check("wr_ack_yumi", mem_resp_yumi_o, 1);
    step;
    n_wr++;
    mem_resp_v_i = 1'b0;
    probe_idle("wr_done_idle");
  endtask
  initial begin
    logic [511:0] d;
    logic [39:0] a;
    dma_pkt_i = '0;
    dma_pkt_v_i = 1'b1;
    dma_data_ready_i = 1'b0;
    dma_data_i = '0;
    dma_data_v_i = 1'b0;
    mem_cmd_ready_i = 1'b0;
    mem_resp_i = '0;
    mem_resp_v_i = 1'b0;
    reset_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pkt_yumi", dma_pkt_yumi_o, 0);
    check("rst_fill_v", dma_data_v_o, 0);
    check("rst_evict_yumi", dma_data_yumi_o, 0);
    check("rst_cmd_v", mem_cmd_v_o, 0);
    check("rst_resp_yumi", mem_resp_yumi_o, 0);
    dma_pkt_v_i = 1'b0;
    reset_i = 1'b0;
    step;
    for (int i = 0; i < N; i++) d[i*64 +: 64] = 64'h1111 * i;
    do_read(40'h00_8000_0048, d, 0, 0, N);
    for (int i = 0; i < N; i++) d[i*64 +: 64] = 64'hA0 + i;
    do_write(40'h00_8000_0100, d, 0);
    do_read(rand_addr(), rand_blk(), 5, 1, N);
    do_write(rand_addr(), rand_blk(), 5);
    a = rand_addr();
    d = rand_blk();
    mem_resp_i = mk_msg(e_cce_mem_rd, a, d);
    mem_resp_v_i = 1'b1;
    repeat (4) begin
      step;
      check("stray_idle_yumi", mem_resp_yumi_o, 0);
    end
    do_read(a, d, 2, 0, N);
    do_read(rand_addr(), rand_blk(), 0, 0, 3);
    check("mid_fill_v", dma_data_v_o, 1);
    #2 reset_i = 1'b1;
    #1;
    check("rst_async_fill_v", dma_data_v_o, 0);
    check("rst_async_cmd_v", mem_cmd_v_o, 0);
    n_rd = 0;
    n_wr = 0;
    step;
    reset_i = 1'b0;
    step;
    do_read(rand_addr(), rand_blk(), 0, 2, N);
    repeat (20) begin
      if ($urandom_range(0, 1) == 1) do_read(rand_addr(), rand_blk(), $urandom_range(0, 3), 2, N);
      else do_write(rand_addr(), rand_blk(), $urandom_range(0, 3));
    end
`ifdef BP_ME_CACHE_DMA_TO_CCE_STATS_EN
    check("stats_rd", rd_count_o, n_rd);
    check("stats_wr", wr_count_o, n_wr);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
